// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, selectable parity / one or two stop bits,
// break detection and a first-word-fall-through receive FIFO with a valid/ready handshake.
module uart_rx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int scale_WIDTH = 6,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          RX_IN,
  input  logic [scale_WIDTH-1:0]        prescaler,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  input  logic                          STOP2,
  output logic [DATA_WIDTH-1:0]         P_DATA,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic                          Parity_Error,
  output logic                          Stop_Error,
  output logic                          Overrun_Error,
  output logic                          Break_Detect,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [scale_WIDTH-1:0] ONE = scale_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_COMMIT
  } state_t;

  state_t state, state_next;

  logic rx_meta, rx_s, rx_q;
  logic [scale_WIDTH-1:0] presc_l, edge_cnt, half;
  logic par_en_l, par_typ_l, stop2_l;
  logic [BW-1:0] bit_cnt;
  logic samp0, samp1, bit_q;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic par_bit, par_err, stop_err, stop_one;
  logic at_wrap, at_vote, voted, bit_val, start_det, in_frame, is_break;
  logic commit_push, overrun_set, break_set;
  logic full, pop;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  // The third sample is taken live so the vote is usable in the same cycle even at prescaler 4.
  assign half      = presc_l >> 1;
  assign at_wrap   = (edge_cnt == presc_l - ONE);
  assign at_vote   = (edge_cnt == half + ONE);
  assign voted     = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
  assign bit_val   = at_vote ? voted : bit_q;
  assign start_det = rx_q & ~rx_s;
  assign in_frame  = (state != S_IDLE) && (state != S_COMMIT);
  assign is_break  = (shift_reg == '0) && !(par_en_l && par_bit) && !stop_one;
  assign full      = (fifo_count == CW'(FIFO_DEPTH));
  assign pop       = data_valid & data_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start_det) state_next = S_START;
      S_START:  if (at_wrap) state_next = bit_val ? S_IDLE : S_DATA;
      S_DATA:   if (at_wrap && bit_cnt == BW'(DATA_WIDTH - 1))
                  state_next = par_en_l ? S_PARITY : S_STOP1;
      S_PARITY: if (at_wrap) state_next = S_STOP1;
      S_STOP1: begin
        if (at_vote && !stop2_l)      state_next = S_COMMIT;
        else if (at_wrap && stop2_l)  state_next = S_STOP2;
      end
      S_STOP2:  if (at_vote) state_next = S_COMMIT;
      S_COMMIT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // A pop in the commit cycle frees a slot, so a full FIFO still accepts the frame.
  always_comb begin
    commit_push = 1'b0;
    overrun_set = 1'b0;
    break_set   = 1'b0;
    if (state == S_COMMIT) begin
      if (is_break)            break_set   = 1'b1;
      else if (!full || pop)   commit_push = 1'b1;
      else                     overrun_set = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_l   <= '0;
      par_en_l  <= 1'b0;
      par_typ_l <= 1'b0;
      stop2_l   <= 1'b0;
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      samp0     <= 1'b1;
      samp1     <= 1'b1;
      bit_q     <= 1'b1;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      par_err   <= 1'b0;
      stop_err  <= 1'b0;
      stop_one  <= 1'b0;
    end else if (state == S_IDLE) begin
      if (start_det) begin
        presc_l   <= prescaler;
        par_en_l  <= PAR_EN;
        par_typ_l <= PAR_TYP;
        stop2_l   <= STOP2;
        edge_cnt  <= '0;
        bit_cnt   <= '0;
        par_bit   <= 1'b0;
        par_err   <= 1'b0;
        stop_err  <= 1'b0;
        stop_one  <= 1'b0;
      end
    end else if (in_frame) begin
      edge_cnt <= at_wrap ? '0 : edge_cnt + ONE;
      if (edge_cnt == half - ONE) samp0 <= rx_s;
      if (edge_cnt == half)       samp1 <= rx_s;
      if (at_vote)                bit_q <= voted;
      case (state)
        S_DATA: begin
          if (at_vote) shift_reg <= {voted, shift_reg[DATA_WIDTH-1:1]};
          if (at_wrap) bit_cnt <= bit_cnt + BW'(1);
        end
        S_PARITY: if (at_vote) begin
          par_bit <= voted;
          par_err <= voted != (^shift_reg ^ par_typ_l);
        end
        S_STOP1, S_STOP2: if (at_vote) begin
          if (!voted) stop_err <= 1'b1;
          stop_one <= stop_one | voted;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      Overrun_Error <= 1'b0;
      Break_Detect  <= 1'b0;
    end else begin
      Overrun_Error <= overrun_set;
      Break_Detect  <= break_set;
      if (commit_push) begin
        mem[wr_ptr] <= {shift_reg, par_err, stop_err};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (commit_push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (!commit_push && pop) fifo_count <= fifo_count - CW'(1);
    end
  end

  assign head         = mem[rd_ptr];
  assign data_valid   = (fifo_count != '0);
  assign P_DATA       = data_valid ? head[EW-1:2] : '0;
  assign Parity_Error = data_valid & head[1];
  assign Stop_Error   = data_valid & head[0];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: frames are driven bit by bit and popped
// entries are captured at the falling clock edge for comparison against hand-computed values.
module tb_uart_rx_fifo;
  localparam int DW = 8;
  localparam int SW = 6;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          RX_IN = 1'b1;
  logic [SW-1:0] prescaler = SW'(8);
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          STOP2 = 1'b0;
  logic          data_ready = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          data_valid, Parity_Error, Stop_Error, Overrun_Error, Break_Detect;
  logic [2:0]    fifo_count;

  int checks = 0;
  int failures = 0;
  int ovr_cnt = 0;
  int brk_cnt = 0;
  int valid_cycles = 0;
  logic [9:0] popped [$];

  uart_rx_fifo #(.DATA_WIDTH(DW), .scale_WIDTH(SW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .RX_IN(RX_IN), .prescaler(prescaler),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .P_DATA(P_DATA), .data_valid(data_valid), .data_ready(data_ready),
    .Parity_Error(Parity_Error), .Stop_Error(Stop_Error),
    .Overrun_Error(Overrun_Error), .Break_Detect(Break_Detect),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Capture every accepted head entry and every pulse, away from the rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid && data_ready) popped.push_back({P_DATA, Parity_Error, Stop_Error});
      if (data_valid) valid_cycles++;
      if (Overrun_Error) ovr_cnt++;
      if (Break_Detect) brk_cnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic checkEntry(input string tag, input int idx, input logic [7:0] d,
                            input logic pe, input logic se);
    checkOutput({tag, "_present"}, 32'(popped.size() > idx), 32'd1);
    if (popped.size() > idx) checkOutput(tag, 32'(popped[idx]), 32'({d, pe, se}));
  endtask

  task automatic clearMon();
    popped.delete();
    ovr_cnt = 0;
    brk_cnt = 0;
    valid_cycles = 0;
  endtask

  task automatic driveBit(input logic v);
    RX_IN = v;
    repeat (int'(prescaler)) @(posedge clk);
    #1;
  endtask

  // One-cycle inversion on the middle majority sample of the bit.
  task automatic driveSpike(input logic v);
    int p;
    p = int'(prescaler);
    RX_IN = v;
    repeat (p / 2 + 1) @(posedge clk);
    #1 RX_IN = ~v;
    @(posedge clk);
    #1 RX_IN = v;
    repeat (p - p / 2 - 2) @(posedge clk);
    #1;
  endtask

  task automatic idleBits(input int n);
    repeat (n) driveBit(1'b1);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic par_on, input logic pbit,
                           input int nstop, input logic s1, input logic s2, input int spike_idx);
    driveBit(1'b0);
    for (int i = 0; i < DW; i++) begin
      if (i == spike_idx) driveSpike(d[i]);
      else                driveBit(d[i]);
    end
    if (par_on) driveBit(pbit);
    driveBit(s1);
    if (nstop == 2) driveBit(s2);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_p_data", 32'(P_DATA), 32'h0);
    checkOutput("rst_valid", 32'(data_valid), 32'h0);
    checkOutput("rst_count", 32'(fifo_count), 32'h0);
    checkOutput("rst_overrun", 32'(Overrun_Error), 32'h0);
    checkOutput("rst_break", 32'(Break_Detect), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    idleBits(2);

    // 8E1 at prescaler 8, consumer always ready
    prescaler = SW'(8); PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; data_ready = 1'b1;
    clearMon();
    sendFrame(8'hA5, 1'b1, 1'b0, 1, 1'b1, 1'b1, -1);
    idleBits(2);
    checkOutput("a5_count", 32'(popped.size()), 32'd1);
    checkEntry("a5_entry", 0, 8'hA5, 1'b0, 1'b0);
    checkOutput("a5_valid_cycles", 32'(valid_cycles), 32'd1);

    clearMon();
    sendFrame(8'h3C, 1'b1, 1'b1, 1, 1'b1, 1'b1, -1);
    sendFrame(8'h81, 1'b1, 1'b0, 1, 1'b0, 1'b1, -1);
    idleBits(2);
    checkEntry("3c_parity_err", 0, 8'h3C, 1'b1, 1'b0);
    checkEntry("81_stop_err", 1, 8'h81, 1'b0, 1'b1);

    // 8N2 at prescaler 16
    prescaler = SW'(16); PAR_EN = 1'b0; STOP2 = 1'b1;
    clearMon();
    sendFrame(8'h5A, 1'b0, 1'b0, 2, 1'b1, 1'b0, -1);
    idleBits(2);
    sendFrame(8'h5A, 1'b0, 1'b0, 2, 1'b1, 1'b1, -1);
    idleBits(2);
    checkEntry("stop2_bad", 0, 8'h5A, 1'b0, 1'b1);
    checkEntry("stop2_good", 1, 8'h5A, 1'b0, 1'b0);

    // Back-to-back frames with the consumer stalled: fifth frame overruns
    prescaler = SW'(8); STOP2 = 1'b0; data_ready = 1'b0;
    clearMon();
    for (int v = 1; v <= 5; v++) sendFrame(8'(v), 1'b0, 1'b0, 1, 1'b1, 1'b1, -1);
    idleBits(2);
    @(negedge clk);
    checkOutput("ovr_count_full", 32'(fifo_count), 32'd4);
    checkOutput("ovr_pulses", 32'(ovr_cnt), 32'd1);
    checkOutput("ovr_head_valid", 32'(data_valid), 32'd1);
    checkOutput("ovr_head_data", 32'(P_DATA), 32'h01);
    @(posedge clk);
    #1 data_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("ovr_popped", 32'(popped.size()), 32'd4);
    for (int i = 0; i < 4; i++) checkEntry($sformatf("ovr_pop%0d", i), i, 8'(i + 1), 1'b0, 1'b0);
    checkOutput("ovr_drained", 32'(fifo_count), 32'd0);

    // Short start glitch, then a clean frame and a frame with a spiked data bit
    clearMon();
    RX_IN = 1'b0;
    repeat (2) @(posedge clk);
    #1 RX_IN = 1'b1;
    idleBits(3);
    checkOutput("glitch_no_push", 32'(popped.size()), 32'd0);
    checkOutput("glitch_count", 32'(fifo_count), 32'd0);
    sendFrame(8'h96, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1);
    idleBits(2);
    checkEntry("after_glitch", 0, 8'h96, 1'b0, 1'b0);
    sendFrame(8'h33, 1'b0, 1'b0, 1, 1'b1, 1'b1, 2);
    sendFrame(8'hCC, 1'b0, 1'b0, 1, 1'b1, 1'b1, 3);
    idleBits(2);
    checkEntry("spike_low_bit", 1, 8'h33, 1'b0, 1'b0);
    checkEntry("spike_high_bit", 2, 8'hCC, 1'b0, 1'b0);

    // Line held low for 12 bit times
    clearMon();
    RX_IN = 1'b0;
    repeat (12 * 8) @(posedge clk);
    #1 RX_IN = 1'b1;
    idleBits(2);
    checkOutput("break_pulses", 32'(brk_cnt), 32'd1);
    checkOutput("break_no_overrun", 32'(ovr_cnt), 32'd0);
    checkOutput("break_no_push", 32'(popped.size()), 32'd0);
    checkOutput("break_count", 32'(fifo_count), 32'd0);

    // Reset while two entries are queued and a frame is in flight
    data_ready = 1'b0;
    clearMon();
    sendFrame(8'h11, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1);
    sendFrame(8'h22, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1);
    idleBits(1);
    checkOutput("pre_rst_count", 32'(fifo_count), 32'd2);
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    reset = 1'b1;
    #2;
    checkOutput("midrst_valid", 32'(data_valid), 32'd0);
    checkOutput("midrst_count", 32'(fifo_count), 32'd0);
    checkOutput("midrst_p_data", 32'(P_DATA), 32'h0);
    RX_IN = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idleBits(3);
    checkOutput("post_rst_count", 32'(fifo_count), 32'd0);
    checkOutput("post_rst_pulses", 32'(ovr_cnt + brk_cnt), 32'd0);
    data_ready = 1'b1;
    sendFrame(8'h5C, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1);
    idleBits(2);
    checkEntry("post_rst_frame", 0, 8'h5C, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised next-generation UART receiver. Adds runtime-selectable one or two stop bits and 3-sample majority voting. Adds a receive FIFO with a valid/ready output handshake, per-entry error tags, overrun reporting and break detection. Sits between the serial pin and the system-side consumer; replaces the single-register receiver where back-pressure is required.

Parameters:
DATA_WIDTH, 8, data bits per frame (legal 5..9), LSB first on the line
scale_WIDTH, 6, width of prescaler and edge counter
FIFO_DEPTH, 4, receive FIFO entries (power of two, >=2)

Ports:
clk  input  1  single system clock
reset  input  1  asynchronous, active-high reset
RX_IN  input  1  serial line, idle high, asynchronous to clk
prescaler  input  scale_WIDTH  clocks per bit (legal >=4); latched at start-bit detection
PAR_EN  input  1  parity bit present; latched at start detection
PAR_TYP  input  1  0 even, 1 odd; latched at start detection
STOP2  input  1  1 = two stop bits expected; latched at start detection
P_DATA  output  DATA_WIDTH  FIFO head data
data_valid  output  1  FIFO head valid
data_ready  input  1  consumer accepts head when data_valid&data_ready
Parity_Error  output  1  parity-error tag of head entry (0 when PAR_EN was 0)
Stop_Error  output  1  stop-error tag of head entry
Overrun_Error  output  1  one-cycle pulse: completed frame dropped, FIFO full
Break_Detect  output  1  one-cycle pulse: break frame seen
fifo_count  output  clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (async, active-high): FSM to IDLE. FIFO empty. All outputs 0 (P_DATA 0, fifo_count 0).
- RX_IN passes through a 2-flop synchroniser (reset value 1); all logic uses the synchronised value rx_s.
- Edge counter 0..P-1, P = latched prescaler; bit counter advances when edge counter wraps.
- Sampling: rx_s taken at edges P/2-1, P/2, P/2+1 (integer division). Sampled bit = majority of 3, valid at edge P/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, COMMIT.
- IDLE: on rx_s falling to 0, latch prescaler/PAR_EN/PAR_TYP/STOP2 and enter START with edge counter 0.
- START: voted bit 1 -> glitch; return to IDLE at the end of the bit period, nothing pushed.
- DATA: shift in DATA_WIDTH voted bits, LSB first.
- PARITY: entered only if PAR_EN. par_err = voted bit != (XOR of data ^ PAR_TYP).
- STOP1: voted 0 -> stop_err. If STOP2, go to STOP2; either stop bit 0 sets stop_err.
- FSM leaves the last stop state immediately after its vote (edge P/2+2), not at the bit end, so a back-to-back start bit is not missed. It goes through COMMIT (one cycle) to IDLE.
- COMMIT checks break first: all data bits 0, parity bit 0 (if enabled) and all stop bits 0 -> Break_Detect pulse, no push, no Overrun_Error.
- COMMIT otherwise: if FIFO not full, push {data, par_err, stop_err}. If full, drop the frame and pulse Overrun_Error; FIFO contents are unchanged.
- After a break, FSM waits in IDLE until rx_s is 1 before a new start can be detected.
- Latency: push in the COMMIT cycle. data_valid is high the next cycle when the FIFO was empty; P_DATA/tags are valid with it.
- FIFO outputs are registered head (first-word fall-through). The head is stable while data_valid & !data_ready.
- Push and pop in the same cycle: occupancy is unchanged. This is legal when full; that case counts as not-full for the push.
- Pointers wrap modulo FIFO_DEPTH. fifo_count is never > FIFO_DEPTH. data_ready while empty is ignored.
- Input config changes mid-frame do not affect the frame in progress.
- Reset asserted mid-frame or with a non-empty FIFO: immediate return to reset state, all entries discarded, no pulses.

Test Plan:
- prescaler=8, PAR_EN=1, PAR_TYP=0, STOP2=0, data_ready=1; send 0xA5, parity 0, stop 1 -> one data_valid cycle, P_DATA=0xA5, Parity_Error=0, Stop_Error=0.
- Same config; send 0x3C with parity 1, then 0x81 with stop 0 -> entry 1 has Parity_Error=1; entry 2 has P_DATA=0x81, Stop_Error=1.
- STOP2=1, PAR_EN=0, prescaler=16; second stop bit 0 -> Stop_Error=1. Both stops 1 -> Stop_Error=0.
- data_ready=0, FIFO_DEPTH=4; send 5 frames 0x01..0x05 back-to-back -> fifo_count=4, Overrun_Error pulses once on frame 5. Then assert data_ready -> pops 0x01,0x02,0x03,0x04 in order.
- Drive RX_IN low for 1/4 bit then high -> no push, FSM back in IDLE. Single-cycle spike inside a data bit -> majority vote gives the correct byte.
- Hold RX_IN low for 12 bit times (8N1) -> Break_Detect pulse, no FIFO push. Assert reset mid-frame with 2 entries queued -> data_valid=0, fifo_count=0 immediately.
